demux32_deserializer: RTL and testbench
=======================================

Name: demux32_deserializer

Overview:
Inverse of the mux32 path: converts a serial bit stream into parallel words by steering each accepted bit into position `ptr` of a 32-bit accumulator, where `ptr` is an internal 5-bit write pointer decoded to a one-hot write enable. Completed words move into a single output holding register with a valid/ready handshake. A flush request emits a partial, zero-padded word. It sits between a serial source (bit-banged link, or a mux32 sweep) and word-wide consumers.

Parameters:
N, 32, word width in bits; must be a power of two and at least 2. Widths derived from it: PTR_W = $clog2(N), CNT_W = PTR_W+1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset (asserted when 0).
in_bit  input  1  serial data bit.
in_valid  input  1  in_bit is valid this cycle.
in_ready  output  1  block can accept in_bit this cycle.
flush  input  1  level request to emit the pending partial word; source holds it until flush_ack.
flush_ack  output  1  one-cycle pulse: flush consumed.
out_word  output  N  assembled word; bit i is the i-th bit accepted (LSB first).
out_count  output  CNT_W  number of valid bits in out_word (1..N).
out_valid  output  1  out_word/out_count valid.
out_ready  input  1  consumer accepts out_word this cycle.

Behaviour:
- Reset (rst=0, asynchronous): ptr=0, acc=0, out_word=0, out_count=0, out_valid=0, flush_ack=0. Asserting reset mid-word discards partial bits with no output.
- Accept: a bit is accepted when in_valid && in_ready. On the next edge, acc[ptr] <= in_bit and ptr <= ptr+1. Only the decoded bit is written; all other acc bits hold.
- slot_free = !out_valid || out_ready.
- in_ready = (ptr != N-1) || slot_free. It is combinational from out_ready; no combinational path exists from in_valid.
- Word complete: accepting a bit with ptr==N-1 loads the output register on the same edge: out_word <= acc with bit N-1 = in_bit, out_count <= N, out_valid <= 1. On that edge ptr wraps to 0 and acc clears to 0. Latency is 1 cycle from the last accepted bit to out_valid.
- Output handshake: out_valid && out_ready clears out_valid on the next edge, unless a new load happens on that same edge, in which case out_valid stays 1 with the new data. out_word/out_count hold their value while out_valid=1 && out_ready=0.
- Flush (fires when flush=1 and flush_ack was 0 last cycle):
  - Define eff_cnt = ptr + (bit accepted this cycle ? 1 : 0).
  - eff_cnt==0: flush_ack pulses next cycle; no output.
  - eff_cnt>0 and slot_free: the output register loads the effective acc (including the bit accepted this cycle) with out_count=eff_cnt. ptr and acc clear, and flush_ack pulses on the same edge.
  - eff_cnt>0 and !slot_free: the flush waits with no ack. Bits may still be accepted while it waits.
  - eff_cnt==N is treated as a normal completion and counts as the flush.
- flush_ack is never high in two consecutive cycles.
- Partial words are zero-padded: bits at position eff_cnt and above are 0.

Decomposition:
- Package demux32_pkg holds:
  - localparams WORD_W=32, PTR_W=5, CNT_W=6;
  - typedef word_t (logic [WORD_W-1:0]);
  - typedef ptr_t (logic [PTR_W-1:0]).
- One sub-module: decoder_5to32, a combinational one-hot decoder with ports `sel[4:0]`, `en`, and `out[31:0]`. It produces the accumulator write enables.
- The top level contains the pointer counter, accumulator, output register and flush logic.

Test Plan:
- Alternating pattern: feed 32 bits with in_valid=1 continuously, bit i = i[0] -> out_valid rises 1 cycle after the 32nd accept; out_word=32'hAAAAAAAA, out_count=32; in_ready stays 1 throughout.
- Bit order and back-to-back words: send 32'hDEADBEEF LSB first, then 32'h12345678, with out_ready=0 -> first word holds stable; in_ready drops while ptr==31 of the second word. Raise out_ready -> 32'hDEADBEEF, then 32'h12345678 is loaded on the handshake edge; no bit lost or duplicated.
- Partial flush: bits 1,0,1,1,0, then flush=1 -> out_word=32'h0000000D, out_count=5, flush_ack pulses once, ptr returns to 0. The next full word is correct.
- Flush edge cases:
  - flush with no pending bits -> flush_ack next cycle, out_valid stays 0.
  - flush asserted in the same cycle as the 3rd accepted bit (bits 1,1,1) -> out_word=32'h7, out_count=3.
- Reset mid-word: 17 bits accepted, then rst=0 for 1 cycle asynchronously between edges -> all outputs 0 immediately. The next 32 bits of 32'hFFFFFFFF yield exactly out_word=32'hFFFFFFFF, out_count=32.

Source files
------------

// File: rtl/demux32_pkg.sv
// Shared widths and types for the serial-to-parallel deserializer.
package demux32_pkg;
    localparam int WORD_W = 32;
    localparam int PTR_W  = 5;
    localparam int CNT_W  = 6;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [PTR_W-1:0]  ptr_t;
endpackage

// File: rtl/decoder_5to32.sv
// Combinational one-hot decoder producing the accumulator bit write enables.
module decoder_5to32
    import demux32_pkg::*;
#(
    parameter int SEL_W = PTR_W,
    parameter int OUT_W = WORD_W
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [OUT_W-1:0] out
);
    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
            assign out[gi] = en && (sel == SEL_W'(gi));
        end
    endgenerate
endmodule

// File: rtl/demux32_deserializer.sv
// Serial bit stream to parallel word converter with a single output holding
// register (valid/ready) and a flush path that emits zero-padded partial words.
module demux32_deserializer
    import demux32_pkg::*;
#(
    parameter int N = WORD_W,
    localparam int ADDR_W = $clog2(N),
    localparam int CNT_BITS = ADDR_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_bit,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    output logic                flush_ack,
    output logic [N-1:0]        out_word,
    output logic [CNT_BITS-1:0] out_count,
    output logic                out_valid,
    input  logic                out_ready
);
    logic [ADDR_W-1:0]   ptr_reg;
    logic [N-1:0]        acc_reg;
    logic [N-1:0]        acc_next;
    logic [N-1:0]        we;
    logic [CNT_BITS-1:0] eff_cnt;
    logic                accept;
    logic                last;
    logic                slot_free;
    logic                complete;
    logic                flush_fire;
    logic                flush_load;
    logic                load;

    assign last       = (ptr_reg == ADDR_W'(N - 1));
    assign slot_free  = !out_valid || out_ready;
    assign in_ready   = !last || slot_free;
    assign accept     = in_valid && in_ready;
    assign complete   = accept && last;
    // Level request: re-arm only after the cycle in which the ack was shown.
    assign flush_fire = flush && !flush_ack;
    assign eff_cnt    = {1'b0, ptr_reg} + CNT_BITS'(accept);
    assign flush_load = flush_fire && (eff_cnt != '0) && slot_free && !complete;
    assign load       = complete || flush_load;

    decoder_5to32 #(
        .SEL_W(ADDR_W),
        .OUT_W(N)
    ) u_dec (
        .sel(ptr_reg),
        .en (accept),
        .out(we)
    );

    // Bits above ptr are always zero, so acc_next is already zero-padded.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_acc
            assign acc_next[gi] = we[gi] ? in_bit : acc_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg   <= '0;
            acc_reg   <= '0;
            out_word  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
            flush_ack <= 1'b0;
        end else begin
            if (load) begin
                out_word  <= acc_next;
                out_count <= eff_cnt;
                out_valid <= 1'b1;
                ptr_reg   <= '0;
                acc_reg   <= '0;
            end else begin
                if (accept) begin
                    ptr_reg <= ptr_reg + ADDR_W'(1);
                    acc_reg <= acc_next;
                end
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
            flush_ack <= flush_fire && ((eff_cnt == '0) || slot_free);
        end
    end
endmodule

// File: tb/tb_demux32_deserializer.sv
// Directed bench for demux32_deserializer: inputs change and outputs are
// sampled on the falling edge, the DUT updates on the rising edge.
module tb_demux32_deserializer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_bit;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        flush_ack;
    logic [31:0] out_word;
    logic [5:0]  out_count;
    logic        out_valid;
    logic        out_ready;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    demux32_deserializer dut (
        .clk      (clk),
        .rst      (rst),
        .in_bit   (in_bit),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .flush_ack(flush_ack),
        .out_word (out_word),
        .out_count(out_count),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Sends w[0..n-1] LSB first, one bit per cycle.
    task automatic send_word(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_bit   = w[i];
            cyc();
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_bit = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_word", out_word, 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_ack", 32'(flush_ack), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Alternating pattern, in_ready must stay high throughout.
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_bit   = (i % 2 == 1);
            #1 chk("alt_in_ready", 32'(in_ready), 32'd1);
            cyc();
        end
        in_valid = 1'b0;
        chk("alt_valid", 32'(out_valid), 32'd1);
        chk("alt_word", out_word, 32'hAAAAAAAA);
        chk("alt_count", 32'(out_count), 32'd32);
        cyc();
        chk("alt_drain", 32'(out_valid), 32'd0);

        // Back-to-back words with the consumer stalled.
        out_ready = 1'b0;
        send_word(32'hDEADBEEF, 32);
        chk("b2b_w1_valid", 32'(out_valid), 32'd1);
        chk("b2b_w1_word", out_word, 32'hDEADBEEF);
        send_word(32'h12345678, 31);
        chk("b2b_hold_word", out_word, 32'hDEADBEEF);
        in_valid = 1'b1;
        in_bit   = 1'b0;
        #1 chk("b2b_ready_low", 32'(in_ready), 32'd0);
        cyc();
        chk("b2b_stall_word", out_word, 32'hDEADBEEF);
        chk("b2b_stall_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1 chk("b2b_ready_comb", 32'(in_ready), 32'd1);
        chk("b2b_w1_at_hs", out_word, 32'hDEADBEEF);
        cyc();
        in_valid = 1'b0;
        chk("b2b_w2_valid", 32'(out_valid), 32'd1);
        chk("b2b_w2_word", out_word, 32'h12345678);
        chk("b2b_w2_count", 32'(out_count), 32'd32);
        cyc();
        chk("b2b_drain", 32'(out_valid), 32'd0);

        // Partial flush of 1,0,1,1,0.
        send_word(32'h0000000D, 5);
        flush = 1'b1;
        cyc();
        chk("pf_ack", 32'(flush_ack), 32'd1);
        chk("pf_valid", 32'(out_valid), 32'd1);
        chk("pf_word", out_word, 32'h0000000D);
        chk("pf_count", 32'(out_count), 32'd5);
        flush = 1'b0;
        cyc();
        chk("pf_ack_once", 32'(flush_ack), 32'd0);
        chk("pf_drain", 32'(out_valid), 32'd0);
        send_word(32'hCAFEF00D, 32);
        chk("pf_next_word", out_word, 32'hCAFEF00D);
        chk("pf_next_count", 32'(out_count), 32'd32);
        cyc();

        // Flush with nothing pending.
        flush = 1'b1;
        cyc();
        chk("ef_ack", 32'(flush_ack), 32'd1);
        chk("ef_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;
        cyc();
        chk("ef_ack_clear", 32'(flush_ack), 32'd0);

        // Flush in the same cycle as the third accepted bit.
        send_word(32'h3, 2);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        flush    = 1'b1;
        cyc();
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("sf_ack", 32'(flush_ack), 32'd1);
        chk("sf_word", out_word, 32'h7);
        chk("sf_count", 32'(out_count), 32'd3);
        cyc();

        // Flush waits for a free output slot.
        out_ready = 1'b0;
        send_word(32'h0F0F0F0F, 32);
        send_word(32'h3, 2);
        flush = 1'b1;
        cyc();
        chk("wf_no_ack", 32'(flush_ack), 32'd0);
        chk("wf_hold_word", out_word, 32'h0F0F0F0F);
        cyc();
        chk("wf_no_ack2", 32'(flush_ack), 32'd0);
        out_ready = 1'b1;
        cyc();
        chk("wf_ack", 32'(flush_ack), 32'd1);
        chk("wf_word", out_word, 32'h3);
        chk("wf_count", 32'(out_count), 32'd2);
        flush = 1'b0;
        cyc();
        chk("wf_drain", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-word with a word parked in the output.
        out_ready = 1'b0;
        send_word(32'h5A5A5A5A, 32);
        send_word(32'hFFFFFFFF, 17);
        chk("mr_pre_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_word", out_word, 32'd0);
        chk("mr_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        send_word(32'hFFFFFFFF, 31);
        chk("mr_no_early", 32'(out_valid), 32'd0);
        send_word(32'h1, 1);
        chk("mr_valid_after", 32'(out_valid), 32'd1);
        chk("mr_word_after", out_word, 32'hFFFFFFFF);
        chk("mr_count_after", 32'(out_count), 32'd32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
